// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the instruction and data caches in front of a
// single-ported, line-wide main memory. Each access is stretched over a
// programmable number of BUSY cycles to model memory latency, and completes
// with a one-cycle ack to whichever cache was granted.
module mem_arbiter #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned ADDR    = 32,
    parameter int unsigned LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [ADDR-1:0]  i_addr,
    output logic             i_ack,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_write,
    input  logic [ADDR-1:0]  d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ack,
    output logic [WIDTH-1:0] d_rdata,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    // With a single BUSY cycle that cycle is also the write cycle, so the
    // write strobe has to be raised on the grant edge itself.
    localparam logic            WR_AT_GRANT = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    state_t           state;
    gnt_t             gnt;
    gnt_t             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             wr;

    logic             any_req_c;
    logic             pick_d_c;
    logic             pick_wr_c;

    // Round-robin pick: a lone requester wins, a tie goes to whoever lost last
    always_comb begin
        any_req_c = i_req || d_req;
        pick_d_c  = d_req;
        if (i_req && d_req) begin
            pick_d_c = (last_grant == GNT_I);
        end
        pick_wr_c = pick_d_c && d_write;
    end

    // Access sequencer: grant in IDLE, count out the latency in BUSY, ack in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= GNT_I;
            last_grant <= GNT_D;
            cnt        <= '0;
            wr         <= 1'b0;
            busy       <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        gnt        <= pick_d_c ? GNT_D : GNT_I;
                        last_grant <= pick_d_c ? GNT_D : GNT_I;
                        wr         <= pick_wr_c;
                        mem_addr   <= pick_d_c ? d_addr : i_addr;
                        mem_wdata  <= pick_d_c ? d_wdata : '0;
                        mem_read   <= !pick_wr_c;
                        mem_write  <= WR_AT_GRANT && pick_wr_c;
                        cnt        <= CNT_INIT;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        // Raise the strobe so it covers only the final BUSY cycle
                        if ((cnt == CNT_W'(1)) && wr) begin
                            mem_write <= 1'b1;
                        end
                    end else begin
                        if (!wr) begin
                            if (gnt == GNT_D) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                i_rdata <= mem_rdata;
                            end
                        end
                        if (gnt == GNT_D) begin
                            d_ack <= 1'b1;
                        end else begin
                            i_ack <= 1'b1;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=4 instance with a line memory
// model plus a LATENCY=1 instance; acks are checked against a scoreboard.
module tb_mem_arbiter;

    localparam int unsigned W   = 128;
    localparam int unsigned A   = 32;
    localparam int unsigned LAT = 4;

    typedef struct {
        bit           is_d;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    logic         i_req = 1'b0;
    logic [A-1:0] i_addr = '0;
    logic         i_ack;
    logic [W-1:0] i_rdata;
    logic         d_req = 1'b0;
    logic         d_write = 1'b0;
    logic [A-1:0] d_addr = '0;
    logic [W-1:0] d_wdata = '0;
    logic         d_ack;
    logic [W-1:0] d_rdata;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [W-1:0] mem_rdata;
    logic         busy;

    logic         l1_i_req = 1'b0;
    logic [A-1:0] l1_i_addr = '0;
    logic         l1_i_ack;
    logic [W-1:0] l1_i_rdata;
    logic         l1_d_req = 1'b0;
    logic         l1_d_write = 1'b0;
    logic [A-1:0] l1_d_addr = '0;
    logic [W-1:0] l1_d_wdata = '0;
    logic         l1_d_ack;
    logic [W-1:0] l1_d_rdata;
    logic [A-1:0] l1_mem_addr;
    logic [W-1:0] l1_mem_wdata;
    logic         l1_mem_read;
    logic         l1_mem_write;
    logic [W-1:0] l1_mem_rdata;
    logic         l1_busy;

    logic [W-1:0] mem0 [16];
    exp_t         sb[$];
    exp_t         mon_e;
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           wr_cnt = 0;

    mem_arbiter #(.WIDTH(W), .ADDR(A), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.WIDTH(W), .ADDR(A), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
        .d_req(l1_d_req), .d_write(l1_d_write), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_read(l1_mem_read),
        .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line memory: 16-byte lines, image reloaded while reset is high
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) mem0[k] <= {16{8'(k * 17)}};
        end else if (mem_write) begin
            mem0[mem_addr[7:4]] <= mem_wdata;
        end
    end
    assign mem_rdata    = mem0[mem_addr[7:4]];
    assign l1_mem_rdata = {4{l1_mem_addr}};

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ack monitor: every ack must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_write) wr_cnt++;
        if (!reset && (i_ack || d_ack)) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", W'({i_ack, d_ack}), '0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", W'(d_ack), W'(mon_e.is_d));
                check("ack_both", W'(i_ack && d_ack), '0);
                check("ack_cycle", W'(cyc), W'(mon_e.cyc));
                check("ack_data", mon_e.is_d ? d_rdata : i_rdata, mon_e.data);
            end
        end
    end

    task automatic push_exp(input bit is_d, input logic [W-1:0] data, input int at);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Single access, starting at a negedge while the arbiter is idle
    task automatic access(input bit is_d, input bit wr, input logic [A-1:0] addr,
                          input logic [W-1:0] wdata, input logic [W-1:0] exp);
        int w0;
        if (is_d) begin
            d_req = 1'b1; d_write = wr; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        push_exp(is_d, exp, cyc + LAT + 1);
        w0 = wr_cnt;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("acc_busy", W'(busy), W'(1));
            check("acc_mem_read", W'(mem_read), W'(!wr));
            check("acc_mem_write", W'(mem_write), W'(wr && (k == LAT)));
            check("acc_mem_addr", W'(mem_addr), W'(addr));
        end
        @(negedge clk);
        check("acc_cmd_drop", W'({mem_read, mem_write}), '0);
        i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
        @(negedge clk);
        check("acc_idle", W'(busy), '0);
        check("acc_wr_count", W'(wr_cnt - w0), W'(wr));
    endtask

    // Both caches hold read requests for n accesses; grants must alternate from I
    task automatic both(input logic [A-1:0] ia, input logic [A-1:0] da,
                        input logic [W-1:0] ie, input logic [W-1:0] de, input int n);
        int c0;
        c0 = cyc;
        i_req = 1'b1; i_addr = ia;
        d_req = 1'b1; d_write = 1'b0; d_addr = da;
        for (int k = 0; k < n; k++) push_exp(k % 2 == 1, (k % 2 == 1) ? de : ie, c0 + 5 + 6 * k);
        for (int t = 1; t <= 6 * n; t++) begin
            @(negedge clk);
            check("rr_busy", W'(busy), W'(t % 6 != 0));
            if (t == 5 + 6 * (n - 2)) i_req = 1'b0;
            if (t == 5 + 6 * (n - 1)) d_req = 1'b0;
        end
    endtask

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), '0);
        check("rst_acks", W'({i_ack, d_ack}), '0);
        check("rst_cmd", W'({mem_read, mem_write}), '0);
        check("rst_i_rdata", i_rdata, '0);
        check("rst_d_rdata", d_rdata, '0);
        check("rst_mem_addr", W'(mem_addr), '0);

        // Simultaneous requests straight out of reset: I first, then D
        reset = 1'b0;
        both(32'h30, 32'h40, {16{8'h33}}, {16{8'h44}}, 2);

        access(1'b0, 1'b0, 32'h10, '0, {16{8'h11}});
        // Write leaves d_rdata at the last D read (line 4)
        access(1'b1, 1'b1, 32'h20, {16{8'hA5}}, {16{8'h44}});
        access(1'b1, 1'b0, 32'h20, '0, {16{8'hA5}});

        both(32'h10, 32'h20, {16{8'h11}}, {16{8'hA5}}, 6);

        // Reset during BUSY of a write aborts it with no write issued
        w0 = wr_cnt;
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h50; d_wdata = {16{8'h5A}};
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; d_req = 1'b0; d_write = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_cmd", W'({mem_read, mem_write}), '0);
        check("mid_rst_acks", W'({i_ack, d_ack}), '0);
        check("mid_rst_addr", W'(mem_addr), '0);
        check("mid_rst_wdata", mem_wdata, '0);
        check("mid_rst_d_rdata", d_rdata, '0);
        check("mid_rst_i_rdata", i_rdata, '0);
        @(negedge clk);
        reset = 1'b0;
        both(32'h50, 32'h10, {16{8'h55}}, {16{8'h11}}, 2);
        check("mid_rst_no_write", W'(wr_cnt - w0), '0);

        // LATENCY=1 instance: one BUSY cycle, ack in cycle 2
        l1_d_req = 1'b1; l1_d_write = 1'b0; l1_d_addr = 32'h1234_5670;
        @(negedge clk);
        check("l1_rd_busy", W'({l1_busy, l1_mem_read, l1_mem_write}), W'(3'b110));
        check("l1_rd_noack", W'(l1_d_ack), '0);
        @(negedge clk);
        check("l1_rd_cmd_drop", W'({l1_mem_read, l1_mem_write}), '0);
        check("l1_rd_ack", W'({l1_i_ack, l1_d_ack}), W'(2'b01));
        check("l1_rd_data", l1_d_rdata, {4{32'h1234_5670}});
        l1_d_req = 1'b0;
        @(negedge clk);
        check("l1_rd_idle", W'({l1_busy, l1_d_ack}), '0);
        l1_d_req = 1'b1; l1_d_write = 1'b1; l1_d_addr = 32'h0000_0080; l1_d_wdata = {16{8'hC3}};
        @(negedge clk);
        check("l1_wr_cmd", W'({l1_mem_read, l1_mem_write}), W'(2'b01));
        check("l1_wr_wdata", l1_mem_wdata, {16{8'hC3}});
        @(negedge clk);
        check("l1_wr_cmd_drop", W'({l1_mem_read, l1_mem_write}), '0);
        check("l1_wr_ack", W'(l1_d_ack), W'(1));
        check("l1_wr_rdata_kept", l1_d_rdata, {4{32'h1234_5670}});
        l1_d_req = 1'b0; l1_d_write = 1'b0;
        @(negedge clk);

        check("sb_empty", W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
